// File: rtl/bcd_display_mux_pkg.sv
// Shared constants for the BCD display multiplexer: capture FSM encodings,
// active-low 7-segment glyphs ({g,f,e,d,c,b,a}) and the digit glyph lookup.
package bcd_display_mux_pkg;

  // Capture FSM state encodings
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_DONE = 2'd1;
  localparam logic [1:0] RELEASE   = 2'd2;

  // Special glyphs
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [6:0] SEG_E   = 7'h06;

  // Decimal digit glyphs, common-anode (0 = segment lit)
  localparam logic [6:0] SEG_DIGIT_0 = 7'h40;
  localparam logic [6:0] SEG_DIGIT_1 = 7'h79;
  localparam logic [6:0] SEG_DIGIT_2 = 7'h24;
  localparam logic [6:0] SEG_DIGIT_3 = 7'h30;
  localparam logic [6:0] SEG_DIGIT_4 = 7'h19;
  localparam logic [6:0] SEG_DIGIT_5 = 7'h12;
  localparam logic [6:0] SEG_DIGIT_6 = 7'h02;
  localparam logic [6:0] SEG_DIGIT_7 = 7'h78;
  localparam logic [6:0] SEG_DIGIT_8 = 7'h00;
  localparam logic [6:0] SEG_DIGIT_9 = 7'h10;

  // Map one nibble to its glyph; anything that is not a decimal digit shows 'E'
  function automatic logic [6:0] digit_glyph(input logic [3:0] nibble);
    logic [6:0] g;
    case (nibble)
      4'd0:    g = SEG_DIGIT_0;
      4'd1:    g = SEG_DIGIT_1;
      4'd2:    g = SEG_DIGIT_2;
      4'd3:    g = SEG_DIGIT_3;
      4'd4:    g = SEG_DIGIT_4;
      4'd5:    g = SEG_DIGIT_5;
      4'd6:    g = SEG_DIGIT_6;
      4'd7:    g = SEG_DIGIT_7;
      4'd8:    g = SEG_DIGIT_8;
      4'd9:    g = SEG_DIGIT_9;
      default: g = SEG_E;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bcd_display_mux_bcd_to_seg7.sv
// Combinational nibble-to-segment decoder with a blanking override.
module bcd_to_seg7
  import bcd_display_mux_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  // Blanked positions go fully dark, otherwise decode the nibble
  always_comb begin
    seg_o = SEG_OFF;
    if (!blank_i) begin
      seg_o = digit_glyph(nibble_i);
    end
  end

endmodule

// File: rtl/bcd_display_mux.sv
// Captures a packed BCD value from the binary-to-BCD converter through a
// start/done handshake and scans it onto a common-anode 7-segment bank with
// leading-zero blanking.
module bcd_display_mux
  import bcd_display_mux_pkg::*;
#(
  parameter int N_DIGITS    = 6,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  output logic                  conv_start,
  input  logic                  conv_done,
  input  logic [4*N_DIGITS-1:0] conv_bcd,
  output logic                  busy,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CNT_W = $clog2(REFRESH_DIV);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  // Capture side
  logic [1:0]            state_q, state_d;
  logic                  pending_q, pending_d;
  logic                  conv_start_q;
  logic                  busy_q;
  logic [4*N_DIGITS-1:0] disp_q, disp_d;

  // Scan side
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [6:0]          seg_q, seg_d;

  logic [N_DIGITS-1:0] lz_blank;
  logic [3:0]          cur_nibble;
  logic                cur_blank;

  // Capture FSM next state: a req that arrives while a transaction is in
  // flight is remembered as a single pending request
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    disp_d    = disp_q;
    case (state_q)
      IDLE: begin
        // conv_done here is stale from the previous transaction and ignored
        if (req || pending_q) begin
          state_d   = WAIT_DONE;
          pending_d = 1'b0;
        end
      end
      WAIT_DONE: begin
        if (req) begin
          pending_d = 1'b1;
        end
        if (conv_done) begin
          disp_d  = conv_bcd;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (req) begin
          pending_d = 1'b1;
        end
        // Wait for the converter to acknowledge the dropped start
        if (!conv_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture FSM registers; handshake outputs are decoded from the next state
  // so they line up with the state they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pending_q    <= 1'b0;
      conv_start_q <= 1'b0;
      busy_q       <= 1'b0;
      disp_q       <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      conv_start_q <= (state_d == WAIT_DONE);
      busy_q       <= (state_d != IDLE);
      disp_q       <= disp_d;
    end
  end

  // Refresh counter and digit index advance
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Leading-zero mask: digit i is dark when it and every higher nibble are
  // zero; digit 0 always shows so that a zero value reads as "0"
  always_comb begin : blank_scan
    logic all_zero;
    all_zero = 1'b1;
    lz_blank = '0;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      all_zero    = all_zero && (disp_q[4*i +: 4] == 4'd0);
      lz_blank[i] = all_zero;
    end
  end

  assign cur_nibble = disp_q[{idx_q, 2'b00} +: 4];
  assign cur_blank  = lz_blank[idx_q];

  bcd_to_seg7 u_glyph (
    .nibble_i (cur_nibble),
    .blank_i  (cur_blank),
    .seg_o    (seg_d)
  );

  // Exactly one anode low: the one selected by the current digit index
  always_comb begin
    an_d = ~(N_DIGITS'(1) << idx_q);
  end

  // Scan registers; anode and segment outputs update together so a digit
  // slot never shows a mix of old and new values
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      an_q  <= '1;
      seg_q <= SEG_OFF;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign conv_start = conv_start_q;
  assign busy       = busy_q;
  assign an         = an_q;
  assign seg        = seg_q;

endmodule

// File: tb/tb_bcd_display_mux.sv
// Bench for bcd_display_mux: behavioural converter, table of display values,
// scoreboard of expected display contents, plus handshake corner sequences.
module tb_bcd_display_mux;

  localparam int ND       = 6;
  localparam int RD       = 4;
  localparam int DONE_DLY = 40;
  localparam int N_VEC    = 6;
  localparam int BOUND    = 200;

  logic            clk = 1'b0;
  logic            rst, req;
  logic            conv_start, conv_done, busy;
  logic [4*ND-1:0] conv_bcd;
  logic [ND-1:0]   an;
  logic [6:0]      seg;

  logic            model_done = 1'b0;
  logic            spur_done  = 1'b0;
  int              model_cnt  = 0;
  logic [4*ND-1:0] model_val  = '0;

  logic            start_prev  = 1'b0;
  int              start_rises = 0;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [4*ND-1:0]    val;
    logic [ND-1:0][6:0] exp;
  } vec_t;

  vec_t vecs [N_VEC];
  int   sb_q [$];

  always #5 clk = ~clk;

  assign conv_done = model_done | spur_done;
  assign conv_bcd  = model_val;

  bcd_display_mux #(
    .N_DIGITS    (ND),
    .REFRESH_DIV (RD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .conv_start (conv_start),
    .conv_done  (conv_done),
    .conv_bcd   (conv_bcd),
    .busy       (busy),
    .an         (an),
    .seg        (seg)
  );

  // Converter model: done rises DONE_DLY cycles after start, falls once start drops
  always @(posedge clk) begin
    if (!conv_start) begin
      model_cnt  <= 0;
      model_done <= 1'b0;
    end else if (model_cnt == DONE_DLY - 1) begin
      model_done <= 1'b1;
    end else begin
      model_cnt <= model_cnt + 1;
    end
  end

  always @(posedge clk) begin
    start_prev <= conv_start;
    if (conv_start && !start_prev) start_rises <= start_rises + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // which: 0 = conv_done high, 1 = busy low
  task automatic wait_cond(input string name, input int which);
    int n;
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < BOUND) begin
      @(negedge clk);
      n++;
      if (which == 0) hit = (conv_done == 1'b1);
      else            hit = (busy == 1'b0);
    end
    if (!hit) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Watch two full scan rotations: one-hot-low anodes, ascending order,
  // RD cycles per slot, and the glyph shown in each slot
  task automatic scan_check(input string name, input logic [ND-1:0][6:0] exp);
    logic [6:0] got [ND];
    logic [ND-1:0] seen;
    int prev_idx, run, idx, zeros;
    bit full_run, bad_onehot, bad_order, bad_len;
    seen = '0;
    prev_idx = -1;
    run = 0;
    full_run = 1'b0;
    bad_onehot = 1'b0;
    bad_order = 1'b0;
    bad_len = 1'b0;
    for (int i = 0; i < ND; i++) got[i] = 7'bx;
    repeat (2 * ND * RD + 4) begin
      @(negedge clk);
      idx = -1;
      zeros = 0;
      for (int i = 0; i < ND; i++) begin
        if (an[i] == 1'b0) begin
          zeros++;
          idx = i;
        end
      end
      if (zeros != 1) begin
        bad_onehot = 1'b1;
      end else begin
        if (!seen[idx] || seg !== exp[idx]) got[idx] = seg;
        seen[idx] = 1'b1;
        if (idx != prev_idx) begin
          if (prev_idx >= 0) begin
            if (idx != (prev_idx + 1) % ND) bad_order = 1'b1;
            if (full_run && run != RD) bad_len = 1'b1;
            full_run = 1'b1;
          end
          prev_idx = idx;
          run = 1;
        end else begin
          run++;
        end
      end
    end
    check({name, ".an_onehot"}, {31'd0, bad_onehot}, 32'd0);
    check({name, ".an_order"}, {31'd0, bad_order}, 32'd0);
    check({name, ".slot_len"}, {31'd0, bad_len}, 32'd0);
    for (int i = 0; i < ND; i++)
      check($sformatf("%s.seg%0d", name, i), {25'd0, got[i]}, {25'd0, exp[i]});
  endtask

  task automatic pulse_req();
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic pop_and_scan(input string name);
    int vi;
    if (sb_q.size() == 0) begin
      check({name, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      vi = sb_q.pop_front();
      repeat (2) @(negedge clk);
      scan_check($sformatf("%s_%06h", name, vecs[vi].val), vecs[vi].exp);
    end
  endtask

  // One full capture transaction with handshake timing checks
  task automatic do_txn(input int vi);
    model_val = vecs[vi].val;
    sb_q.push_back(vi);
    pulse_req();
    check("start_after_req", {31'd0, conv_start}, 32'd1);
    check("busy_after_req", {31'd0, busy}, 32'd1);
    wait_cond("done_rise", 0);
    @(negedge clk);
    check("release_start_low", {31'd0, conv_start}, 32'd0);
    check("release_busy_high", {31'd0, busy}, 32'd1);
    wait_cond("busy_fall", 1);
    check("idle_start_low", {31'd0, conv_start}, 32'd0);
    pop_and_scan("txn");
  endtask

  initial begin
    int r0;
    bit bad;

    vecs[0].val = 24'h000123; vecs[0].exp = {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30};
    vecs[1].val = 24'h0A0100; vecs[1].exp = {7'h7F, 7'h06, 7'h40, 7'h79, 7'h40, 7'h40};
    vecs[2].val = 24'h000000; vecs[2].exp = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
    vecs[3].val = 24'h987654; vecs[3].exp = {7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19};
    vecs[4].val = 24'h100000; vecs[4].exp = {7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    vecs[5].val = 24'hF00005; vecs[5].exp = {7'h06, 7'h40, 7'h40, 7'h40, 7'h40, 7'h12};

    rst = 1'b1;
    req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_an", {26'd0, an}, {26'd0, 6'b111111});
    check("rst_seg", {25'd0, seg}, 32'h7F);
    check("rst_start", {31'd0, conv_start}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    // Idle after reset: zero value shows a lone "0" on digit 0
    sb_q.push_back(2);
    pop_and_scan("idle");
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_start", {31'd0, conv_start}, 32'd0);

    // Table of values through full transactions
    for (int k = 0; k < N_VEC; k++) do_txn(k);

    // Two reqs during WAIT_DONE collapse into exactly one follow-up transaction
    r0 = start_rises;
    model_val = vecs[4].val;
    pulse_req();
    repeat (5) @(negedge clk);
    pulse_req();
    repeat (3) @(negedge clk);
    pulse_req();
    wait_cond("pend_done1", 0);
    model_val = vecs[5].val;
    sb_q.push_back(5);
    wait_cond("pend_idle1", 1);
    @(negedge clk);
    check("pend_restart_start", {31'd0, conv_start}, 32'd1);
    check("pend_restart_busy", {31'd0, busy}, 32'd1);
    wait_cond("pend_done2", 0);
    wait_cond("pend_idle2", 1);
    repeat (60) @(negedge clk);
    check("pend_start_rises", start_rises - r0, 32'd2);
    check("pend_no_third", {31'd0, busy}, 32'd0);
    pop_and_scan("pend");

    // Reset in the middle of WAIT_DONE
    model_val = vecs[3].val;
    pulse_req();
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_start", {31'd0, conv_start}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_an", {26'd0, an}, {26'd0, 6'b111111});
    check("mid_rst_seg", {25'd0, seg}, 32'h7F);
    rst = 1'b0;
    sb_q.push_back(2);
    pop_and_scan("after_rst");
    do_txn(0);

    // Stale conv_done in IDLE must not start or capture anything
    model_val = vecs[3].val;
    spur_done = 1'b1;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (conv_start !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    spur_done = 1'b0;
    check("spur_no_action", {31'd0, bad}, 32'd0);
    sb_q.push_back(0);
    pop_and_scan("spur");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_display_mux.md
Name: bcd_display_mux

Overview:
- Downstream consumer of the binary-to-BCD converter: drives its start/done handshake, captures the packed BCD result, and time-multiplexes it onto a common-anode 7-segment display bank.
- Adds leading-zero blanking and an error glyph for non-decimal nibbles.
- Sits between the converter and the board display pins.

Parameters:
- N_DIGITS, 6, number of BCD digits / display positions (6 matches an 18-bit converter).
- REFRESH_DIV, 50000, clock cycles each digit stays lit; must be >= 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  1  one-cycle request to refresh the displayed value from the converter.
- conv_start  output  1  start level to the converter.
- conv_done  input  1  done level from the converter.
- conv_bcd  input  4*N_DIGITS  packed BCD from the converter, digit 0 = bits [3:0] (least significant).
- busy  output  1  high while a capture transaction is in progress.
- an  output  N_DIGITS  anode enables, active-low, one-hot-low.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.

Behaviour:
- Reset values:
  - FSM = IDLE; conv_start = 0; busy = 0; pending = 0.
  - disp_reg = 0; refresh counter = 0; digit index = 0.
  - an = all ones; seg = 7'h7F (all segments off).
- Capture FSM (states IDLE, WAIT_DONE, RELEASE):
  - IDLE:
    - On req or pending: go to WAIT_DONE and clear pending.
    - conv_start = 0, busy = 0.
  - WAIT_DONE:
    - conv_start = 1, busy = 1.
    - When conv_done = 1: latch conv_bcd into disp_reg on that edge, then go to RELEASE.
  - RELEASE:
    - conv_start = 0, busy = 1.
    - When conv_done = 0: go to IDLE.
    - Dropping start returns the converter to its initial state.
  - conv_start and busy are registered FSM outputs. conv_start rises on the first clock edge after req is sampled.
  - req while busy sets pending; multiple reqs while busy collapse to a single pending request.
  - req in IDLE coinciding with a pending flag yields exactly one transaction.
  - conv_done high while in IDLE is ignored; it is stale from a previous transaction.
  - No timeout; WAIT_DONE holds indefinitely.
- Scan:
  - Refresh counter counts 0 to REFRESH_DIV-1 and then wraps.
  - On wrap, digit index advances 0 to N_DIGITS-1 and then wraps to 0.
  - an and seg are registered from the current digit index and disp_reg: one cycle latency after an index change or a disp_reg update.
  - an[i] = 0 only for i = digit index. an never has two zeros in the same cycle.
  - A new disp_reg value takes effect on the next registered output update; there is no tearing within a digit slot.
- Glyphs:
  - Digits 0-9: standard patterns (0 = 7'h40, 1 = 7'h79, 5 = 7'h12, 8 = 7'h00).
  - Nibble > 9: 'E' = 7'h06.
  - Leading-zero blanking: digit i > 0 shows 7'h7F if all nibbles i..N_DIGITS-1 are 0.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
- Mid-operation reset:
  - Returns everything to reset values within the same cycle edge.
  - conv_start drops, so the converter also returns to its initial state; any pending request is lost.

Decomposition:
- Shared package / include holds:
  - FSM state encodings IDLE = 2'd0, WAIT_DONE = 2'd1, RELEASE = 2'd2.
  - Segment constants SEG_OFF = 7'h7F and SEG_E = 7'h06.
  - The 0-9 pattern constants.
- One combinational sub-module: bcd_to_seg7 (4-bit nibble and blank input to 7-bit active-low segments). It is instantiated once on the muxed nibble.

Test Plan (REFRESH_DIV = 4, N_DIGITS = 6, behavioural converter model asserting done 40 cycles after start):
- Reset then idle 30 cycles:
  - conv_start = 0, busy = 0.
  - an cycles through 111110, 111101, … every 4 cycles.
  - seg = 7'h40 on digit 0, 7'h7F on all others.
- req pulse with model returning 0x000123:
  - conv_start high one cycle after req; disp_reg = 0x000123 one cycle after done.
  - Digits 0..2 show 3, 2, 1 (7'h30, 7'h24, 7'h79); digits 3..5 show 7'h7F.
  - conv_start low in RELEASE; busy drops after done falls.
- Two reqs during WAIT_DONE:
  - Exactly one additional transaction after return to IDLE.
  - Total start rising edges = 2.
- Model returns 0x0A0100:
  - Digit 4 shows 'E' (7'h06); digit 3 shows 7'h40, not blanked; digit 5 blanked.
- rst asserted during WAIT_DONE:
  - Next edge: conv_start = 0, busy = 0, an = 6'b111111, seg = 7'h7F, disp_reg = 0.
  - A later req completes normally.
- Spurious conv_done = 1 in IDLE for 5 cycles, no req:
  - No state change; disp_reg unchanged.
